// File: rtl/sm_key_pkg.sv
// Shared types and helpers for the board push-button conditioning path.
// Contents: per-key debounce FSM state encoding and a clog2 helper used to
// size the debounce and auto-repeat counters.
package sm_key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // Bits needed to hold 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32'd32; i++) begin
      if (((value - 32'd1) >> i) != 32'd0) result = i + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sm_key_debounce.sv
// Single-key conditioner: 2-FF synchronizer, counter-based debounce FSM,
// polarity normalisation and one-cycle press/release pulses.
// Optional auto-repeat is built when SM_KEY_AUTOREPEAT_EN is defined;
// otherwise key_repeat is tied to 0.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   key_raw      - asynchronous raw button pin
//   key_state    - debounced level, 1 = pressed
//   key_press    - one-cycle pulse on accepted press
//   key_release  - one-cycle pulse on accepted release
//   key_repeat   - one-cycle auto-repeat pulse while held
module sm_key_debounce
  import sm_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int unsigned       CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic              REL_LVL  = ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_q, key_state_d;
  logic             key_press_q, key_press_d;
  logic             key_release_q, key_release_d;
  logic             pressed_c;

  assign pressed_c = sync2_q ^ ACTIVE_LOW;

  // Debounce FSM: a new level must be seen DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    sync1_d       = key_raw;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    case (state_q)
      RELEASED: begin
        if (pressed_c) begin
          cnt_d   = CNT_W'(1);
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_c) begin
          cnt_d   = '0;
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed_c) begin
          cnt_d   = CNT_W'(1);
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_c) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RELEASED;
      end
    endcase
    // Outputs are registered from the next state so they align with the FSM.
    key_state_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    key_press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    key_release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
  end

  // State and output registers; reset parks the synchronizer at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= REL_LVL;
      sync2_q       <= REL_LVL;
      state_q       <= RELEASED;
      cnt_q         <= '0;
      key_state_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

`ifdef SM_KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = clog2(REP_MAX);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             key_repeat_q, key_repeat_d;

  // Countdown to the next repeat; loaded on press, reloaded with the period on each pulse.
  always_comb begin
    rep_cnt_d    = rep_cnt_q;
    key_repeat_d = 1'b0;
    if (key_press_d) begin
      rep_cnt_d = REP_W'(REPEAT_DELAY - 32'd1);
    end else if (key_state_d) begin
      if (rep_cnt_q == '0) begin
        key_repeat_d = 1'b1;
        rep_cnt_d    = REP_W'(REPEAT_PERIOD - 32'd1);
      end else begin
        rep_cnt_d = rep_cnt_q - REP_W'(1);
      end
    end else begin
      rep_cnt_d = '0;
    end
  end

  // Repeat counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q    <= '0;
      key_repeat_q <= 1'b0;
    end else begin
      rep_cnt_q    <= rep_cnt_d;
      key_repeat_q <= key_repeat_d;
    end
  end

  assign key_repeat = key_repeat_q;
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/sm_key_input.sv
// Board push-button conditioning: WIDTH independent copies of the
// synchronize/debounce/edge-pulse path between raw KEY pins and the core.
// Optional auto-repeat controlled by macro SM_KEY_AUTOREPEAT_EN.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   key_raw      - asynchronous raw button pins
//   key_state    - debounced levels, 1 = pressed
//   key_press    - one-cycle pulses on accepted press
//   key_release  - one-cycle pulses on accepted release
//   key_repeat   - one-cycle auto-repeat pulses (0 when feature not built)
module sm_key_input
  import sm_key_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] key_repeat
);

  // One fully independent conditioner per key.
  for (genvar k = 0; k < int'(WIDTH); k++) begin : g_key
    sm_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (key_raw[k]),
      .key_state   (key_state[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k]),
      .key_repeat  (key_repeat[k])
    );
  end

endmodule

// File: doc/sm_key_input.md
Name: sm_key_input

Overview:
- Input-side counterpart to the board LED output path: conditions raw board push-buttons (KEY*) before they drive core control inputs such as clkEnable or step/run requests.
- Per key: 2-FF synchronization, counter-based debounce, polarity normalisation, single-cycle press/release pulses.
- Sits in the board top between the raw KEY pins and sm_top.

Parameters:
- WIDTH, 2, number of keys handled.
- DEBOUNCE_CYCLES, 1000000, cycles a new level must persist before it is accepted (10 ms at 100 MHz); minimum 2.
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = active-high.
- REPEAT_DELAY, 50000000, cycles held before the first repeat pulse (auto-repeat only).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (auto-repeat only).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key_raw  input  WIDTH  asynchronous raw button pins
- key_state  output  WIDTH  debounced level, 1 = pressed
- key_press  output  WIDTH  1-cycle pulse on accepted press
- key_release  output  WIDTH  1-cycle pulse on accepted release
- key_repeat  output  WIDTH  1-cycle auto-repeat pulse; constant 0 when the feature is out

Behaviour:
- Reset: all outputs 0.
  - Synchronizer flops load the "released" raw level (1 if ACTIVE_LOW, else 0).
  - Counters load 0; FSMs enter RELEASED.
- Polarity: pressed = key_raw XOR ACTIVE_LOW, evaluated after the 2-FF synchronizer (sync2).
- Per-key FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if sync2 = pressed, counter <= 1 and go to PRESS_WAIT.
  - PRESS_WAIT:
    - if sync2 = released, go to RELEASED with counter <= 0 (glitch rejected, no pulse);
    - else if counter = DEBOUNCE_CYCLES-1, go to PRESSED;
    - else counter++.
  - PRESSED and RELEASE_WAIT mirror the above with inverted sense.
- key_state is registered: 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- key_press is registered, high exactly the cycle key_state first reads 1. key_release is the same for 0.
- Latency: a clean edge on key_raw sampled at clock edge N gives key_state/key_press change visible after edge N+1+DEBOUNCE_CYCLES (2 sync + DEBOUNCE_CYCLES-1 count).
- Counter width is clog2(DEBOUNCE_CYCLES). It never wraps; it saturates at the terminal value by construction of the FSM.
- Keys are fully independent; simultaneous events on several keys produce simultaneous pulses.
- Synchronous rst asserted mid-debounce or while pressed returns to the reset state next edge with no release pulse.
- A key held through reset release is re-detected as a new press after the full debounce latency.
- key_press and key_release are never high together for one key.

Optional Feature:
- Macro SM_KEY_AUTOREPEAT_EN.
- Defined:
  - per-key repeat counter runs while the FSM is in PRESSED or RELEASE_WAIT;
  - key_repeat pulses once REPEAT_DELAY cycles after the key_press cycle, then every REPEAT_PERIOD cycles while still pressed;
  - counter clears on key_release or rst;
  - key_press itself is not re-asserted.
- Undefined: repeat logic absent; key_repeat tied to 0; REPEAT_* parameters ignored.

Decomposition:
- Shared package sm_key_pkg:
  - FSM state typedef/encoding (RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - clog2 helper function.
- One sub-module, sm_key_debounce: single-key synchronizer + FSM + optional repeat. sm_key_input instantiates WIDTH copies in a generate loop.

Test Plan:
- Settings for all scenarios: WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Clean press: key_raw[0] 1->0 held, sampled at edge 10 -> key_state[0]=1 and key_press[0] high for one cycle after edge 15; key_release[0] stays 0.
- Glitch rejection: key_raw[0] low for 3 cycles then high -> key_state, key_press, key_release stay 0 throughout.
- Release: from pressed, key_raw[0] 0->1 held -> key_state[0]=0 and one key_release[0] pulse 5 edges after first sampling; no key_press.
- Independence: key_raw[1:0] both pressed same cycle -> key_press=2'b11 for exactly one cycle; key_raw[1] then bounces 0/1 every cycle -> key_state[1] unchanged.
- Reset mid-operation: rst high 1 cycle while key 0 is pressed -> all outputs 0 next cycle, no release pulse; key still held -> new key_press 6 cycles after rst drops.
- Auto-repeat (SM_KEY_AUTOREPEAT_EN defined): hold key 0 for 20 cycles after key_press -> key_repeat[0] pulses at +8, +11, +14, +17, +20; undefined -> key_repeat stays 0.
